// File: rtl/glay_kernel_control_pkg.sv
// Shared types for the GLay ap_ctrl_chain front-end: FSM states, perf record and descriptor layout.
// The perf record is only used when the top is built with GLAY_CONTROL_PERF_EN.
package glay_control_pkg;
  typedef enum logic {S_IDLE = 1'b0, S_DESC = 1'b1} control_state_t;

  localparam int GLAY_CONTROL_MAX_OUTSTANDING = 2;

  typedef struct packed {
    logic [63:0] busy_cycles;
    logic [31:0] launches;
    logic [31:0] stall_cycles;
  } glay_control_perf_t;
endpackage

package glay_descriptor_pkg;
  localparam int GLAY_NUM_ARGS = 9;
  localparam int GLAY_ARG_W    = 64;

  // args[0] sits in the LSBs, matching the packing of args_in.
  typedef struct packed {
    logic [GLAY_NUM_ARGS-1:0][GLAY_ARG_W-1:0] args;
  } glay_desc_t;
endpackage

// File: rtl/glay_control_counter.sv
// Up/down counter that saturates at zero and all-ones; simultaneous inc and dec leave it unchanged.
// o_full flags count >= MAX; o_zero flags count == 0. Both derive from the registered count.
module glay_control_counter #(
  parameter int W   = 4,
  parameter int MAX = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero,
  output logic         o_full
);
  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !(&r_count)) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
  assign o_full  = (r_count >= W'(MAX));
endmodule

// File: rtl/glay_kernel_control.sv
// ap_ctrl_chain front-end for glay_kernel_cu: captures args into a valid/ready descriptor,
// tracks in-flight launches and holds ap_done until ap_continue. GLAY_CONTROL_PERF_EN adds perf counters.
module glay_kernel_control
  import glay_control_pkg::*;
#(
  parameter int NUM_ARGS        = 9,
  parameter int ARG_W           = 64,
  parameter int MAX_OUTSTANDING = GLAY_CONTROL_MAX_OUTSTANDING,
  parameter int CNT_W           = 4
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ap_start,
  input  logic                      ap_continue,
  output logic                      ap_idle,
  output logic                      ap_ready,
  output logic                      ap_done,
  input  logic [NUM_ARGS*ARG_W-1:0] args_in,
  output logic                      desc_valid,
  input  logic                      desc_ready,
  output logic [NUM_ARGS*ARG_W-1:0] desc_payload,
  input  logic                      cu_done,
  output logic [CNT_W-1:0]          launch_count
`ifdef GLAY_CONTROL_PERF_EN
  ,
  output logic [63:0]               perf_busy_cycles,
  output logic [31:0]               perf_launches,
  output logic [31:0]               perf_stall_cycles
`endif
);
  control_state_t            r_state, w_state_nxt;
  logic [NUM_ARGS*ARG_W-1:0] r_payload;
  logic                      r_ap_ready, r_ap_done, r_ap_idle;
  logic                      w_accept, w_launch, w_cont, w_done_inc;
  logic [CNT_W-1:0]          w_in_flight, w_done_pend;
  logic                      w_if_zero, w_if_full, w_dp_zero, w_dp_full;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: if (ap_start && !w_if_full) begin
        w_accept    = 1'b1;
        w_state_nxt = S_DESC;
      end
      S_DESC: if (desc_ready) begin
        w_launch    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A completion beyond the number of launches in flight is a CU protocol error and is dropped.
  assign w_cont     = ap_continue && !w_dp_zero;
  assign w_done_inc = cu_done && (w_done_pend != w_in_flight) && !w_dp_full;

  glay_control_counter #(.W(CNT_W), .MAX(MAX_OUTSTANDING)) u_in_flight (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_inc   (w_launch),
    .i_dec   (w_cont),
    .o_count (w_in_flight),
    .o_zero  (w_if_zero),
    .o_full  (w_if_full)
  );

  glay_control_counter #(.W(CNT_W), .MAX(MAX_OUTSTANDING)) u_done_pend (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_inc   (w_done_inc),
    .i_dec   (w_cont),
    .o_count (w_done_pend),
    .o_zero  (w_dp_zero),
    .o_full  (w_dp_full)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= S_IDLE;
      r_payload  <= '0;
      r_ap_ready <= 1'b0;
      r_ap_done  <= 1'b0;
      r_ap_idle  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      if (w_accept) r_payload <= args_in;
      r_ap_ready <= w_launch;
      r_ap_done  <= !w_dp_zero;
      r_ap_idle  <= (r_state == S_IDLE) && w_if_zero && w_dp_zero;
    end
  end

  assign desc_valid   = (r_state == S_DESC);
  assign desc_payload = r_payload;
  assign ap_ready     = r_ap_ready;
  assign ap_done      = r_ap_done;
  assign ap_idle      = r_ap_idle;
  assign launch_count = w_in_flight;

`ifdef GLAY_CONTROL_PERF_EN
  glay_control_perf_t r_perf;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_perf <= '0;
    end else begin
      if (!r_ap_idle && !(&r_perf.busy_cycles))
        r_perf.busy_cycles <= r_perf.busy_cycles + 64'd1;
      if (w_launch && !(&r_perf.launches))
        r_perf.launches <= r_perf.launches + 32'd1;
      if ((r_state == S_DESC) && !desc_ready && !(&r_perf.stall_cycles))
        r_perf.stall_cycles <= r_perf.stall_cycles + 32'd1;
    end
  end

  assign perf_busy_cycles  = r_perf.busy_cycles;
  assign perf_launches     = r_perf.launches;
  assign perf_stall_cycles = r_perf.stall_cycles;
`endif
endmodule

// File: tb/tb_glay_kernel_control.sv
// Directed bench for glay_kernel_control: launch, backpressure, outstanding limit, done accumulation, async reset.
// Perf counter checks are compiled in with GLAY_CONTROL_PERF_EN.
module tb_glay_kernel_control;
  import glay_descriptor_pkg::*;

  localparam int NUM_ARGS = 9;
  localparam int ARG_W    = 64;
  localparam int CNT_W    = 4;
  localparam int PW       = NUM_ARGS * ARG_W;

  logic             ap_clk, ap_rst_n, ap_start, ap_continue;
  logic             ap_idle, ap_ready, ap_done;
  logic [PW-1:0]    args_in, desc_payload;
  logic             desc_valid, desc_ready, cu_done;
  logic [CNT_W-1:0] launch_count;
`ifdef GLAY_CONTROL_PERF_EN
  logic [63:0]      perf_busy_cycles;
  logic [31:0]      perf_launches, perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  glay_kernel_control #(
    .NUM_ARGS(NUM_ARGS), .ARG_W(ARG_W), .MAX_OUTSTANDING(2), .CNT_W(CNT_W)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (ap_start),
    .ap_continue  (ap_continue),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .args_in      (args_in),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_payload (desc_payload),
    .cu_done      (cu_done),
    .launch_count (launch_count)
`ifdef GLAY_CONTROL_PERF_EN
    ,
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_launches     (perf_launches),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Accept-edge then handshake-edge with desc_ready high.
  task automatic launch();
    ap_start   = 1'b1;
    desc_ready = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
  endtask

  // Retire one in-flight launch: completion, then acknowledge.
  task automatic finish_one();
    cu_done = 1'b1;
    tick();
    cu_done     = 1'b0;
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    tick();
  endtask

  glay_desc_t d_a, d_b, d_obs;
  logic [PW-1:0] held;
  int pulses;

  initial begin
    ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
    desc_ready = 1'b0; cu_done = 1'b0; args_in = '0;
    d_a = '0; d_b = '0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      d_a.args[i] = 64'h1111 * (i + 1);
      d_b.args[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    end
    d_a.args[0] = 64'h1000;
    d_a.args[8] = 64'hBEEF;

    // Reset state
    repeat (3) tick();
    check("rst_idle",  ap_idle, 1);
    check("rst_ready", ap_ready, 0);
    check("rst_done",  ap_done, 0);
    check("rst_dvld",  desc_valid, 0);
    check("rst_pay",   desc_payload, 0);
    check("rst_cnt",   launch_count, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick();

    // Single launch
    args_in    = d_a;
    ap_start   = 1'b1;
    desc_ready = 1'b1;
    tick();
    ap_start = 1'b0;
    d_obs = desc_payload;
    check("t1_dvld",  desc_valid, 1);
    check("t1_arg0",  d_obs.args[0], 64'h1000);
    check("t1_arg8",  d_obs.args[8], 64'hBEEF);
    check("t1_arg3",  d_obs.args[3], 64'h4444);
    check("t1_rdy0",  ap_ready, 0);
    tick();
    check("t1_rdy1",  ap_ready, 1);
    check("t1_dvld0", desc_valid, 0);
    check("t1_cnt1",  launch_count, 1);
    check("t1_busy",  ap_idle, 0);
    tick();
    check("t1_rdy_pulse", ap_ready, 0);
    cu_done = 1'b1;
    tick();
    cu_done = 1'b0;
    tick();
    check("t1_done", ap_done, 1);
    repeat (3) tick();
    check("t1_done_hold", ap_done, 1);
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    tick();
    check("t1_done_clr", ap_done, 0);
    check("t1_idle",     ap_idle, 1);
    check("t1_cnt0",     launch_count, 0);

    // Backpressure: desc_ready low for 5 S_DESC cycles
    args_in    = d_b;
    desc_ready = 1'b0;
    ap_start   = 1'b1;
    tick();
    ap_start = 1'b0;
    args_in  = d_a;
    held = d_b;
    for (int i = 0; i < 5; i++) begin
      check("t2_dvld_held", desc_valid, 1);
      check("t2_pay_stable", desc_payload, held);
      check("t2_no_ready", ap_ready, 0);
      tick();
    end
    desc_ready = 1'b1;
    check("t2_dvld_last", desc_valid, 1);
    tick();
    check("t2_ready", ap_ready, 1);
    check("t2_dvld0", desc_valid, 0);
    check("t2_cnt1",  launch_count, 1);
`ifdef GLAY_CONTROL_PERF_EN
    check("t2_perf_stall", perf_stall_cycles, 5);
    check("t2_perf_launch", perf_launches, 2);
    check("t2_perf_busy_nz", perf_busy_cycles != 0, 1);
`endif
    finish_one();
    check("t2_cnt0", launch_count, 0);
    check("t2_idle", ap_idle, 1);

    // Outstanding limit: start held high, no completions
    ap_start   = 1'b1;
    desc_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ap_ready) pulses++;
    end
    check("t3_pulses2", pulses, 2);
    check("t3_cnt2",    launch_count, 2);
    check("t3_stall",   desc_valid, 0);
    cu_done = 1'b1;
    tick();
    cu_done     = 1'b0;
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    check("t3_cnt1",      launch_count, 1);
    tick();
    check("t3_third_acc", desc_valid, 1);
    tick();
    ap_start = 1'b0;
    check("t3_third_rdy", ap_ready, 1);
    check("t3_cnt2b",     launch_count, 2);

    // Done accumulation: two completions before any continue
    cu_done = 1'b1;
    tick();
    tick();
    cu_done = 1'b0;
    tick();
    check("t4_done", ap_done, 1);
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    tick();
    check("t4_done_after1", ap_done, 1);
    check("t4_cnt1",        launch_count, 1);
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    tick();
    check("t4_done_after2", ap_done, 0);
    check("t4_idle",        ap_idle, 1);
    check("t4_cnt0",        launch_count, 0);

    // Coincident cu_done and ap_continue
    launch();
    launch();
    check("t5_cnt2", launch_count, 2);
    cu_done = 1'b1;
    tick();
    ap_continue = 1'b1;
    tick();
    cu_done     = 1'b0;
    ap_continue = 1'b0;
    check("t5_cnt1", launch_count, 1);
    tick();
    check("t5_done_kept", ap_done, 1);
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    tick();
    check("t5_done_clr", ap_done, 0);
    check("t5_cnt0",     launch_count, 0);
    check("t5_idle",     ap_idle, 1);

    // Async reset while in S_DESC with one launch in flight
    launch();
    desc_ready = 1'b0;
    ap_start   = 1'b1;
    tick();
    ap_start = 1'b0;
    check("t6_pre_dvld", desc_valid, 1);
    check("t6_pre_cnt",  launch_count, 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("t6_rst_idle", ap_idle, 1);
    check("t6_rst_dvld", desc_valid, 0);
    check("t6_rst_cnt",  launch_count, 0);
    check("t6_rst_pay",  desc_payload, 0);
`ifdef GLAY_CONTROL_PERF_EN
    check("t6_rst_perf", perf_launches, 0);
`endif
    #3;
    ap_rst_n   = 1'b1;
    desc_ready = 1'b1;
    tick();
    args_in = d_b;
    launch();
    check("t6_new_rdy", ap_ready, 1);
    check("t6_new_cnt", launch_count, 1);
    check("t6_new_pay", desc_payload, d_b);
    finish_one();
    check("t6_end_idle", ap_idle, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
